// File: rtl/f_le_rr_arbiter_pkg.sv
// Shared definitions for the float comparator arbiter: float format constants
// and the arbiter FSM state encoding.
package f_le_rr_arbiter_pkg;

    localparam int FLEN = 64;
    localparam int NE   = 11;
    localparam int NF   = 52;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // True when the exponent field is all ones, i.e. the operand is Inf or NaN.
    function automatic logic is_special(input logic [FLEN-1:0] x);
        return &x[FLEN-2 -: NE];
    endfunction

endpackage

// File: rtl/f_le_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// ptr, both as a one-hot vector and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int  j;
        logic found;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/f_le_rr_arbiter.sv
// Round-robin arbiter sharing one f_less_or_equal comparator between clients,
// with a bounded lock for back-to-back compares and a 2-stage result path.
module f_le_rr_arbiter
    import f_le_rr_arbiter_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int MAX_LOCK  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CLIENTS-1:0]           req,
    input  logic [N_CLIENTS-1:0]           lock,
    input  logic [N_CLIENTS-1:0][FLEN-1:0] a,
    input  logic [N_CLIENTS-1:0][FLEN-1:0] b,
    output logic [N_CLIENTS-1:0]           gnt,
    output logic [N_CLIENTS-1:0]           res_vld,
    output logic                           res,
    output logic                           err,
    output logic                           busy,
    output logic [FLEN-1:0]                f_le_a,
    output logic [FLEN-1:0]                f_le_b,
    input  logic                           f_le_res,
    input  logic                           f_le_err
);

    localparam int ID_W = $clog2(N_CLIENTS);
    localparam int HC_W = $clog2(MAX_LOCK + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_LOCK);

    typedef logic [ID_W-1:0] client_id_t;

    arb_state_e       state_q, state_d;
    client_id_t       owner_q, owner_d;
    client_id_t       ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic             s1_vld_q, s1_vld_d;
    client_id_t       s1_id_q, s1_id_d;
    logic [FLEN-1:0]  s1_a_q, s1_a_d;
    logic [FLEN-1:0]  s1_b_q, s1_b_d;

    logic             s2_vld_q, s2_vld_d;
    client_id_t       s2_id_q, s2_id_d;
    logic             res_q, res_d;
    logic             err_q, err_d;

    logic [N_CLIENTS-1:0] pick_onehot;
    client_id_t           pick_idx;
    logic [N_CLIENTS-1:0] owner_oh;
    logic                 other_req;
    logic                 forced;
    logic                 xfer;
    client_id_t           win;

    function automatic client_id_t next_id(input client_id_t x);
        return (x == client_id_t'(N_CLIENTS - 1)) ? '0 : x + client_id_t'(1);
    endfunction

    rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            owner_oh[i] = (client_id_t'(i) == owner_q);
        end
    end

    // Grant selection; in LOCKED only the owner may win, unless its hold budget is spent.
    always_comb begin
        gnt       = '0;
        other_req = |(req & ~owner_oh);
        forced    = (state_q == LOCKED) && req[owner_q] &&
                    (hold_cnt_q == HOLD_MAX) && other_req;
        win       = (state_q == LOCKED) ? owner_q : pick_idx;
        if (rst_n) begin
            if (state_q == IDLE) begin
                gnt = pick_onehot;
            end else if (req[owner_q] && !forced) begin
                gnt = owner_oh;
            end
        end
        xfer = |(req & gnt);
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (lock[win]) begin
                        state_d    = LOCKED;
                        owner_d    = win;
                        hold_cnt_d = HC_W'(1);
                    end else begin
                        ptr_d = next_id(win);
                    end
                end
            end
            LOCKED: begin
                // Any release moves the pointer past the owner so it does not win again first.
                if (!req[owner_q] || forced || (xfer && !lock[owner_q])) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    ptr_d      = next_id(owner_q);
                end else if (xfer && hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        s1_vld_d = xfer;
        s1_id_d  = s1_id_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (xfer) begin
            s1_id_d = win;
            s1_a_d  = a[win];
            s1_b_d  = b[win];
        end
        s2_vld_d = s1_vld_q;
        s2_id_d  = s2_id_q;
        res_d    = res_q;
        err_d    = err_q;
        if (s1_vld_q) begin
            s2_id_d = s1_id_q;
            res_d   = f_le_res;
            err_d   = f_le_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            s1_vld_q   <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_id_q    <= '0;
            res_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_vld_q   <= s2_vld_d;
            s2_id_q    <= s2_id_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        res_vld = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            res_vld[i] = s2_vld_q && (client_id_t'(i) == s2_id_q);
        end
    end

    assign res    = res_q;
    assign err    = err_q;
    assign f_le_a = s1_a_q;
    assign f_le_b = s1_b_q;
    assign busy   = s1_vld_q || s2_vld_q || (state_q == LOCKED);

endmodule

// File: tb/tb_f_le_rr_arbiter.sv
// Directed bench for f_le_rr_arbiter with a behavioural f_less_or_equal model
// standing in for the shared comparator.
module tb_f_le_rr_arbiter;
    import f_le_rr_arbiter_pkg::*;

    localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] FOUR  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] V234  = 64'h4002_B851_EB85_1EB8;
    localparam logic [63:0] V56E5 = 64'h4121_1700_0000_0000;
    localparam logic [63:0] V8EM7 = 64'h3EAA_D7F2_9ABC_AF48;
    localparam logic [63:0] QNAN  = 64'h7FF1_2345_6789_ABCD;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [3:0]              req, lock, gnt, res_vld;
    logic [3:0][FLEN-1:0]    a, b;
    logic                    res, err, busy;
    logic [FLEN-1:0]         f_le_a, f_le_b;
    logic                    f_le_res, f_le_err;
    logic [3:0]              fair_res;
    int                      errors = 0;
    int                      checks = 0;

    always #5 clk = ~clk;

    f_le_rr_arbiter #(
        .N_CLIENTS (4),
        .MAX_LOCK  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .a        (a),
        .b        (b),
        .gnt      (gnt),
        .res_vld  (res_vld),
        .res      (res),
        .err      (err),
        .busy     (busy),
        .f_le_a   (f_le_a),
        .f_le_b   (f_le_b),
        .f_le_res (f_le_res),
        .f_le_err (f_le_err)
    );

    // Behavioural double-precision a <= b with an error flag for Inf/NaN operands.
    function automatic logic [1:0] fle_model(input logic [63:0] x, input logic [63:0] y);
        logic e, le;
        e = (x[62:52] == 11'h7FF) || (y[62:52] == 11'h7FF);
        if (x[62:0] == 63'd0 && y[62:0] == 63'd0) le = 1'b1;
        else if (x[63] != y[63])                  le = x[63];
        else if (!x[63])                          le = (x[62:0] <= y[62:0]);
        else                                      le = (x[62:0] >= y[62:0]);
        return {e, le};
    endfunction

    always_comb {f_le_err, f_le_res} = fle_model(f_le_a, f_le_b);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change 2 time units after the edge, outputs settle 2 units later.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] l,
                                 input int ci, input logic [63:0] av, input logic [63:0] bv);
        @(posedge clk);
        #2;
        rst_n = rst;
        req   = r;
        lock  = l;
        if (ci >= 0) begin
            a[ci] = av;
            b[ci] = bv;
        end
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        a     = '0;
        b     = '0;

        applyStimulus(1'b0, 4'b1111, 4'b0000, -1, 0, 0);
        checkOutput("rst_gnt", gnt, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("rst_res_vld", res_vld, 4'b0000);
        checkOutput("rst_res", res, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_f_le_a", f_le_a, 64'd0);
        checkOutput("rst_f_le_b", f_le_b, 64'd0);

        applyStimulus(1'b1, 4'b0100, 4'b0000, 2, ONE, FOUR);
        checkOutput("single_gnt", gnt, 4'b0100);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("single_f_le_a", f_le_a, ONE);
        checkOutput("single_f_le_b", f_le_b, FOUR);
        checkOutput("single_busy", busy, 1'b1);
        checkOutput("single_early_vld", res_vld, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("single_res_vld", res_vld, 4'b0100);
        checkOutput("single_res", res, 1'b1);
        checkOutput("single_err", err, 1'b0);

        a[0] = ONE;  b[0] = FOUR;
        a[1] = FOUR; b[1] = ONE;
        a[3] = FOUR; b[3] = FOUR;
        fair_res = 4'b1101;
        applyStimulus(1'b0, 4'b1111, 4'b0000, -1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, (k < 8) ? 4'b1111 : 4'b0000, 4'b0000, -1, 0, 0);
            if (k < 8)
                checkOutput($sformatf("fair_gnt%0d", k), gnt, 4'b0001 << (k % 4));
            if (k >= 2) begin
                checkOutput($sformatf("fair_vld%0d", k), res_vld, 4'b0001 << ((k - 2) % 4));
                checkOutput($sformatf("fair_res%0d", k), res, fair_res[(k - 2) % 4]);
            end
        end

        applyStimulus(1'b1, 4'b1010, 4'b0010, 1, V234, V56E5);
        checkOutput("lock_gnt0", gnt, 4'b0010);
        applyStimulus(1'b1, 4'b1010, 4'b0010, 1, V56E5, V8EM7);
        checkOutput("lock_gnt1", gnt, 4'b0010);
        checkOutput("lock_f_le_a", f_le_a, V234);
        applyStimulus(1'b1, 4'b1010, 4'b0000, 1, V8EM7, V234);
        checkOutput("lock_gnt2", gnt, 4'b0010);
        checkOutput("lock_vld0", res_vld, 4'b0010);
        checkOutput("lock_res0", res, 1'b1);
        applyStimulus(1'b1, 4'b1000, 4'b0000, -1, 0, 0);
        checkOutput("lock_gnt3", gnt, 4'b1000);
        checkOutput("lock_vld1", res_vld, 4'b0010);
        checkOutput("lock_res1", res, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("lock_vld2", res_vld, 4'b0010);
        checkOutput("lock_res2", res, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("lock_vld3", res_vld, 4'b1000);
        checkOutput("lock_res3", res, 1'b1);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'b0101, 4'b0001, -1, 0, 0);
            checkOutput($sformatf("bound_gnt%0d", k), gnt, 4'b0001);
        end
        applyStimulus(1'b1, 4'b0101, 4'b0001, -1, 0, 0);
        checkOutput("bound_idle", gnt, 4'b0000);
        checkOutput("bound_busy", busy, 1'b1);
        applyStimulus(1'b1, 4'b0101, 4'b0001, -1, 0, 0);
        checkOutput("bound_next", gnt, 4'b0100);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("bound_vld", res_vld, 4'b0100);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0010, -1, 0, 0);
            checkOutput($sformatf("sat_gnt%0d", k), gnt, 4'b0010);
        end
        applyStimulus(1'b1, 4'b1010, 4'b0010, -1, 0, 0);
        checkOutput("sat_forced", gnt, 4'b0000);
        applyStimulus(1'b1, 4'b1000, 4'b0000, -1, 0, 0);
        checkOutput("sat_next", gnt, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);

        applyStimulus(1'b1, 4'b1000, 4'b0000, 3, QNAN, ONE);
        checkOutput("err_gnt", gnt, 4'b1000);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("err_vld", res_vld, 4'b1000);
        checkOutput("err_flag", err, 1'b1);

        applyStimulus(1'b1, 4'b0010, 4'b0000, -1, 0, 0);
        checkOutput("mid_gnt", gnt, 4'b0010);
        applyStimulus(1'b0, 4'b1111, 4'b0000, -1, 0, 0);
        checkOutput("mid_rst_gnt", gnt, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("mid_res_vld", res_vld, 4'b0000);
        checkOutput("mid_busy", busy, 1'b0);
        checkOutput("mid_f_le_a", f_le_a, 64'd0);
        checkOutput("mid_res", res, 1'b0);
        checkOutput("mid_err", err, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, -1, 0, 0);
        checkOutput("mid_late_vld", res_vld, 4'b0000);
        applyStimulus(1'b1, 4'b1111, 4'b0000, -1, 0, 0);
        checkOutput("mid_first_gnt", gnt, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
